inst_loader: RTL and testbench

Switch-driven writer for the pipeline's instruction memory. It captures 16-bit instructions from the switches on debounced push-button presses and writes them to consecutive addresses of an internal instruction RAM. It serves the pipeline's fetch reads through a registered read port, so a program is entered by hand and then run. It sits between the board I/O (SW/KEY) and the fetch stage, in place of the fixed ROM.

---
 rtl/inst_loader_pkg.sv | 21 ++
 rtl/key_debounce.sv | 49 ++++
 rtl/inst_loader.sv | 120 ++++++++++++
 tb/tb_inst_loader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared definitions for the switch-driven instruction loader.
// - Default geometry and debounce constants.
// - FSM state encoding.
// - Board KEY[] index mapping, for the wrapper that splits the KEY bus.
package inst_loader_pkg;
    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_DEB_CYCLES = 4;

    // KEY[] bit for each loader button (KEY[0] is left to the system reset)
    localparam int KEY_STORE = 1;
    localparam int KEY_RUN   = 2;
    localparam int KEY_CLEAR = 3;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;
endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, then a stability counter.
// Ports:
//   clk, reset - system clock, synchronous active-low reset
//   key        - raw active-low button
//   level      - debounced level (1 = released)
//   press      - one-cycle strobe on the debounced 1->0 transition
// The level flips only after DEB_CYCLES consecutive synchronized samples
// that all differ from it; press rises with the new level, so the total
// latency is 2 + DEB_CYCLES cycles from a stable low input.
module key_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1, sync2;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            level      <= 1'b1;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != level) begin
                if (stable_cnt == CW'(DEB_CYCLES - 1)) begin
                    level      <= sync2;
                    stable_cnt <= '0;
                    press      <= ~sync2;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                // any sample agreeing with the current level restarts the run
                stable_cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/inst_loader.sv
// Switch-driven instruction RAM writer with a registered fetch read port.
// Ports:
//   clk, reset                    - system clock, synchronous active-low reset
//   key_store/key_run/key_clear   - active-low buttons
//   sw_inst                       - instruction from switches
//   rd_addr, rd_data              - fetch port, 1-cycle registered, low bits only
//   running                       - pipeline released
//   full, count                   - words written since last clear
//   last_addr, last_data          - most recent write, for the HEX display
//   wr_pulse                      - high for the single cycle of each RAM write
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_store,
    input  logic              key_run,
    input  logic              key_clear,
    input  logic [DATA_W-1:0] sw_inst,
    input  logic [31:0]       rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              running,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] last_addr,
    output logic [DATA_W-1:0] last_data,
    output logic              wr_pulse
);
    localparam int DEPTH = 1 << ADDR_W;

    state_t            state, state_nxt;
    logic              store_lvl, store_p, run_p, clear_p;
    logic              run_lvl, clear_lvl;
    logic              do_clear, do_latch;
    logic [DATA_W-1:0] latch_data;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              unused_addr_bits;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_store (
        .clk(clk), .reset(reset), .key(key_store), .level(store_lvl), .press(store_p));
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run (
        .clk(clk), .reset(reset), .key(key_run), .level(run_lvl), .press(run_p));
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clear (
        .clk(clk), .reset(reset), .key(key_clear), .level(clear_lvl), .press(clear_p));

    // fetch uses only the low address bits; the rest wrap
    assign unused_addr_bits = ^{rd_addr[31:ADDR_W], run_lvl, clear_lvl};

    assign wr_pulse = (state == ST_WRITE);
    assign running  = (state == ST_RUN);
    // stores are refused once full, so count can never pass DEPTH
    assign full     = (count == (ADDR_W + 1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_LOAD;
        else        state <= state_nxt;
    end

    // priority in LOAD: clear > run > store
    always_comb begin
        state_nxt = state;
        do_clear  = 1'b0;
        do_latch  = 1'b0;
        case (state)
            ST_LOAD: begin
                if (clear_p)               do_clear = 1'b1;
                else if (run_p)            state_nxt = ST_RUN;
                else if (store_p && !full) begin
                    do_latch  = 1'b1;
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: state_nxt = ST_HOLD;
            ST_HOLD: begin
                // wait for store release so one press never writes twice
                if (clear_p)   do_clear  = 1'b1;
                if (store_lvl) state_nxt = ST_LOAD;
            end
            ST_RUN: begin
                if (clear_p) begin
                    do_clear  = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count      <= '0;
            last_addr  <= '0;
            last_data  <= '0;
            latch_data <= '0;
        end else begin
            if (do_latch) latch_data <= sw_inst;
            if (wr_pulse) begin
                last_addr <= count[ADDR_W-1:0];
                last_data <= latch_data;
                count     <= count + 1'b1;
            end
            if (do_clear) count <= '0;
        end
    end

    // RAM is never cleared; a write on a reset edge is dropped
    always_ff @(posedge clk) begin
        if (reset && wr_pulse) mem[count[ADDR_W-1:0]] <= latch_data;
    end

    // non-blocking read gives old data on a same-address write
    always_ff @(posedge clk) begin
        if (!reset) rd_data <= '0;
        else        rd_data <= mem[rd_addr[ADDR_W-1:0]];
    end
endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;
    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        key_store = 1'b1, key_run = 1'b1, key_clear = 1'b1;
    logic [15:0] sw_inst = '0;
    logic [31:0] rd_addr = '0;

    logic [15:0] rd_data0, rd_data1, last_data0, last_data1;
    logic        running0, running1, full0, full1, wr_pulse0, wr_pulse1;
    logic [8:0]  count0;
    logic [2:0]  count1;
    logic [7:0]  last_addr0;
    logic [1:0]  last_addr1;

    always #5 clk = ~clk;

    inst_loader #(.ADDR_W(8), .DATA_W(16), .DEB_CYCLES(DEB)) u_dut (
        .clk(clk), .reset(reset), .key_store(key_store), .key_run(key_run),
        .key_clear(key_clear), .sw_inst(sw_inst), .rd_addr(rd_addr), .rd_data(rd_data0),
        .running(running0), .full(full0), .count(count0), .last_addr(last_addr0),
        .last_data(last_data0), .wr_pulse(wr_pulse0));

    inst_loader #(.ADDR_W(2), .DATA_W(16), .DEB_CYCLES(DEB)) u_dut4 (
        .clk(clk), .reset(reset), .key_store(key_store), .key_run(key_run),
        .key_clear(key_clear), .sw_inst(sw_inst), .rd_addr(rd_addr), .rd_data(rd_data1),
        .running(running1), .full(full1), .count(count1), .last_addr(last_addr1),
        .last_data(last_data1), .wr_pulse(wr_pulse1));

    // reference model: one entry per DUT (0: 256 words, 1: 4 words)
    typedef struct { int addr; logic [15:0] data; } wr_t;
    wr_t         q0[$], q1[$];
    int          depth[2] = '{256, 4};
    int          m_cnt[2];
    bit          m_run[2];
    logic [15:0] m_mem[2][256];
    bit          m_known[2][256];

    int n_pass = 0, n_total = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic model_press(bit st, bit rn, bit cl, logic [15:0] d);
        for (int i = 0; i < 2; i++) begin
            if (m_run[i]) begin
                if (cl) begin m_cnt[i] = 0; m_run[i] = 0; end
            end else if (cl) begin
                m_cnt[i] = 0;
            end else if (rn) begin
                m_run[i] = 1;
            end else if (st && m_cnt[i] < depth[i]) begin
                wr_t w;
                w.addr = m_cnt[i];
                w.data = d;
                if (i == 0) q0.push_back(w); else q1.push_back(w);
                m_mem[i][m_cnt[i]]   = d;
                m_known[i][m_cnt[i]] = 1;
                m_cnt[i]++;
            end
        end
    endtask

    task automatic drive(bit st, bit rn, bit cl, int hold, logic [15:0] d);
        @(negedge clk);
        sw_inst   = d;
        key_store = ~st; key_run = ~rn; key_clear = ~cl;
        repeat (hold) @(negedge clk);
        key_store = 1'b1; key_run = 1'b1; key_clear = 1'b1;
        repeat (DEB + 8) @(negedge clk);
    endtask

    task automatic press(bit st, bit rn, bit cl, logic [15:0] d, int hold);
        model_press(st, rn, cl, d);
        drive(st, rn, cl, hold, d);
    endtask

    task automatic check_state();
        chk("count0", 32'(count0), 32'(m_cnt[0]));
        chk("full0", 32'(full0), 32'(m_cnt[0] == depth[0]));
        chk("running0", 32'(running0), 32'(m_run[0]));
        chk("count1", 32'(count1), 32'(m_cnt[1]));
        chk("full1", 32'(full1), 32'(m_cnt[1] == depth[1]));
        chk("running1", 32'(running1), 32'(m_run[1]));
    endtask

    task automatic check_read(logic [31:0] a);
        int i0, i1;
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        i0 = int'(a % 256);
        i1 = int'(a % 4);
        if (m_known[0][i0]) chk("rd_data0", 32'(rd_data0), 32'(m_mem[0][i0]));
        if (m_known[1][i1]) chk("rd_data1", 32'(rd_data1), 32'(m_mem[1][i1]));
    endtask

    // monitor: compare each write one cycle after its strobe, once the
    // display registers have taken the written address/data
    bit  pend0 = 0, pend1 = 0;
    wr_t e0, e1;
    always @(negedge clk) begin
        if (pend0) begin
            if (q0.size() == 0) chk("unexpected_write0", 32'(last_addr0), 32'hFFFF_FFFF);
            else begin
                e0 = q0.pop_front();
                chk("wr_addr0", 32'(last_addr0), 32'(e0.addr));
                chk("wr_data0", 32'(last_data0), 32'(e0.data));
            end
        end
        if (pend1) begin
            if (q1.size() == 0) chk("unexpected_write1", 32'(last_addr1), 32'hFFFF_FFFF);
            else begin
                e1 = q1.pop_front();
                chk("wr_addr1", 32'(last_addr1), 32'(e1.addr));
                chk("wr_data1", 32'(last_data1), 32'(e1.data));
            end
        end
        pend0 = wr_pulse0;
        pend1 = wr_pulse1;
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_run[i] = 0;
            for (int j = 0; j < 256; j++) m_known[i][j] = 0;
        end

        // reset
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_count0", 32'(count0), 0);
        chk("rst_full0", 32'(full0), 0);
        chk("rst_running0", 32'(running0), 0);
        chk("rst_last_addr0", 32'(last_addr0), 0);
        chk("rst_last_data0", 32'(last_data0), 0);
        chk("rst_wr_pulse0", 32'(wr_pulse0), 0);
        chk("rst_rd_data0", 32'(rd_data0), 0);
        chk("rst_count1", 32'(count1), 0);
        chk("rst_rd_data1", 32'(rd_data1), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // store sequence
        press(1, 0, 0, 16'h0123, DEB + 2);
        press(1, 0, 0, 16'h1456, DEB + 2);
        press(1, 0, 0, 16'h9A07, DEB + 2);
        check_state();
        chk("seq_last_addr", 32'(last_addr0), 2);
        chk("seq_last_data", 32'(last_data0), 32'h9A07);
        check_read(32'd1);

        // bounce: too short, then a long hold that writes once
        drive(1, 0, 0, DEB - 1, 16'hDEAD);
        check_state();
        press(1, 0, 0, 16'hBEEF, 50);
        check_state();

        // small DUT is full now; its 5th store is refused
        press(1, 0, 0, 16'h5555, DEB + 2);
        check_state();
        check_read(32'd0);

        // run / clear
        press(0, 0, 1, 16'h0, DEB + 2);
        press(1, 0, 0, 16'hA001, DEB + 2);
        press(1, 0, 0, 16'hA002, DEB + 2);
        press(0, 1, 0, 16'h0, DEB + 2);
        check_state();
        press(1, 0, 0, 16'hFFFF, DEB + 2);
        check_state();
        check_read(32'h0000_0101);
        press(0, 0, 1, 16'h0, DEB + 2);
        check_state();
        press(1, 0, 0, 16'h7777, DEB + 2);
        check_state();

        // simultaneous presses
        press(1, 1, 0, 16'h3333, DEB + 2);
        check_state();
        press(0, 0, 1, 16'h0, DEB + 2);
        press(0, 1, 1, 16'h0, DEB + 2);
        check_state();

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            int r, h;
            logic [15:0] d;
            r = $urandom_range(0, 9);
            h = $urandom_range(DEB, DEB + 6);
            d = 16'($urandom);
            case (r)
                0, 1, 2, 3, 4, 5: press(1, 0, 0, d, h);
                6: press(0, 1, 0, d, h);
                7: press(0, 0, 1, d, h);
                8: check_read($urandom);
                default: press(1, 1, 0, d, h);
            endcase
            check_state();
        end

        repeat (4) @(negedge clk);
        chk("pending_writes0", 32'(q0.size()), 0);
        chk("pending_writes1", 32'(q1.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
